inst_fetch_unit: RTL and testbench

- Parametrised instruction fetch stage that succeeds the single-ROM fetch block.
- Holds the fetch PC and an internal instruction ROM (array `rom`, preloadable hierarchically by benches, word-indexed).
- Has a small prefetch queue and drives a valid/ready stream of {pc, inst} to decode.
- Supports backpressure, branch/jump redirect with flush, and address-fault reporting.

---
 rtl/fetch_pkg.sv | 39 +++
 rtl/fetch_queue.sv | 89 ++++++++
 rtl/inst_fetch_unit.sv | 141 ++++++++++++++
 tb/tb_inst_fetch_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : fetch_pkg                                                     |
// | Purpose: Shared types, constants and address helpers for the fetch     |
// |          stage and its queue.                                          |
// | Contents:                                                              |
// |   INST_NOP       - instruction word returned for a faulting fetch      |
// |   fetch_entry_t  - {pc, inst, fault} entry at the default 32-bit width |
// |   word_index()   - byte address to word index (callers truncate)       |
// |   addr_fault()   - misaligned or out-of-range address detection        |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
package fetch_pkg;

  localparam int FETCH_XLEN = 32;
  // Helpers work on a 64-bit view so any XLEN up to 64 can call them.
  localparam int ADDR_MAX_W = 64;

  localparam logic [FETCH_XLEN-1:0] INST_NOP = '0;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] inst;
    logic                  fault;
  } fetch_entry_t;

  // Full word index; the caller keeps the low $clog2(DEPTH) bits, which
  // equals pc[$clog2(DEPTH)+1:2].
  function automatic logic [ADDR_MAX_W-1:0] word_index(input logic [ADDR_MAX_W-1:0] addr);
    return addr >> 2;
  endfunction

  function automatic logic addr_fault(input logic [ADDR_MAX_W-1:0] addr,
                                      input logic [ADDR_MAX_W-1:0] depth);
    return (addr[1:0] != 2'b00) || (word_index(addr) >= depth);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : fetch_queue                                                   |
// | Purpose: Small synchronous FIFO of fetch entries with flush.           |
// |          Pointer-and-count organisation, pointers wrap at QDEPTH so    |
// |          non-power-of-two depths work.                                 |
// | Ports  : clk, rst (async, active-high)                                 |
// |          flush      - empties the queue, wins over push/pop            |
// |          push, push_data - write one entry                             |
// |          pop        - remove the head entry                            |
// |          head, valid, count - head entry, non-empty flag, occupancy    |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int  QDEPTH  = 2,
  parameter type entry_t = fetch_entry_t,
  localparam int CW      = $clog2(QDEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  entry_t        push_data,
  input  logic          pop,
  output entry_t        head,
  output logic          valid,
  output logic [CW-1:0] count
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  entry_t        mem_q [QDEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    do_pop   = pop && (count_q != '0);
    // A full queue still accepts a push when the head leaves on the same edge.
    do_push  = push && ((count_q != CW'(QDEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; only the pointers and count define contents.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign valid = (count_q != '0);
  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/inst_fetch_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : inst_fetch_unit                                               |
// | Purpose: Instruction fetch stage: fetch PC, internal word-indexed ROM  |
// |          (rom[], synchronous read), prefetch queue and a valid/ready   |
// |          {pc, inst, fault} stream towards decode. Supports redirect    |
// |          with flush and halts after issuing a faulting address.        |
// | Ports  : clk, rst (async, active-high)                                 |
// |          redirect_valid, redirect_pc - one-cycle PC change request     |
// |          out_ready  - decode accepts head entry                        |
// |          out_valid, out_pc, out_inst, out_fault - head entry           |
// |          pc         - next address to be issued                        |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 256,
  parameter int RESET_PC = 0,
  parameter int QDEPTH   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_inst,
  output logic            out_fault,
  output logic [XLEN-1:0] pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(QDEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            fault;
  } entry_t;

  // Instruction memory, loaded from outside (hierarchical preload).
  logic [XLEN-1:0] rom [DEPTH];

  logic [XLEN-1:0] pc_q, pc_d;
  logic            halted_q, halted_d;
  logic            inflight_q, inflight_d;
  logic [XLEN-1:0] infl_pc_q, infl_pc_d;
  logic            infl_fault_q, infl_fault_d;
  logic [XLEN-1:0] rom_data_q;

  logic [AW-1:0]   rd_idx;
  logic            fault_now;
  logic            pop;
  logic            issue;
  logic [CW:0]     occupancy;
  logic            q_valid;
  logic [CW-1:0]   q_count;
  entry_t          q_head;
  entry_t          push_entry;

  always_comb begin
    rd_idx    = AW'(word_index(ADDR_MAX_W'(pc_q)));
    fault_now = addr_fault(ADDR_MAX_W'(pc_q), ADDR_MAX_W'(DEPTH));
    pop       = q_valid && out_ready;
    // Slots already promised: queued + in flight, less the one leaving now.
    occupancy = {1'b0, q_count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
    issue     = !halted_q && !redirect_valid && (occupancy < (CW+1)'(QDEPTH));
  end

  always_comb begin
    pc_d         = pc_q;
    halted_d     = halted_q;
    inflight_d   = issue;
    infl_pc_d    = infl_pc_q;
    infl_fault_d = infl_fault_q;
    if (redirect_valid) begin
      pc_d       = redirect_pc;
      halted_d   = 1'b0;
      inflight_d = 1'b0;
    end else if (issue) begin
      pc_d         = pc_q + XLEN'(4);
      infl_pc_d    = pc_q;
      infl_fault_d = fault_now;
      if (fault_now) halted_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q         <= XLEN'(RESET_PC);
      halted_q     <= 1'b0;
      inflight_q   <= 1'b0;
      infl_pc_q    <= '0;
      infl_fault_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      halted_q     <= halted_d;
      inflight_q   <= inflight_d;
      infl_pc_q    <= infl_pc_d;
      infl_fault_q <= infl_fault_d;
    end
  end

  // Synchronous ROM read port; the data is only consumed while inflight_q.
  always_ff @(posedge clk) begin
    if (issue) rom_data_q <= rom[rd_idx];
  end

  always_comb begin
    push_entry.pc    = infl_pc_q;
    push_entry.inst  = infl_fault_q ? XLEN'(INST_NOP) : rom_data_q;
    push_entry.fault = infl_fault_q;
  end

  fetch_queue #(
    .QDEPTH  (QDEPTH),
    .entry_t (entry_t)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (inflight_q && !redirect_valid),
    .push_data (push_entry),
    .pop       (pop),
    .head      (q_head),
    .valid     (q_valid),
    .count     (q_count)
  );

  // Head fields read as zero when empty so outputs are clean after reset/flush.
  assign out_valid = q_valid;
  assign out_pc    = q_valid ? q_head.pc    : '0;
  assign out_inst  = q_valid ? q_head.inst  : '0;
  assign out_fault = q_valid ? q_head.fault : 1'b0;
  assign pc        = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : tb_inst_fetch_unit                                            |
// | Purpose: Scoreboard bench for inst_fetch_unit. Stimulus pushes the     |
// |          entries decode should receive; a negedge monitor pops and     |
// |          compares on every handshake.                                  |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module tb_inst_fetch_unit;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_fault;
  logic [31:0] pc;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  inst_fetch_unit #(
    .XLEN(32), .DEPTH(256), .RESET_PC(0), .QDEPTH(2)
  ) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_ready(out_ready), .out_valid(out_valid),
    .out_pc(out_pc), .out_inst(out_inst), .out_fault(out_fault),
    .pc(pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] rom_word(input int i);
    case (i)
      0: return 32'h20100005;
      1: return 32'h20100006;
      2: return 32'h012A4820;
      3: return 32'h012A4822;
      4: return 32'h012A4822;
      5: return 32'h112A002A;
      6: return 32'h112A002B;
      7: return 32'h8C0A0000;
      8: return 32'h34E700FF;
      default: return 32'hC0000000 + 32'(i);
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic expect_seq(input logic [31:0] start, input int n);
    for (int k = 0; k < n; k++) begin
      logic [31:0] a;
      a = start + 32'(4 * k);
      exp_q.push_back('{pc: a, inst: rom_word(int'(a >> 2)), fault: 1'b0});
    end
  endtask

  // Waits until every expected entry has been handed over; bounded.
  task automatic drain(output int cyc);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries never delivered, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Called at posedge+1; returns at posedge+1 two edges after the redirect edge.
  task automatic do_redirect(input logic [31:0] tgt, input logic rdy);
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    out_ready      = rdy;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    check("redir_valid_n", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check("redir_valid_n1", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check("redir_valid_n2", 64'(out_valid), 64'd1);
    check("redir_target_pc", 64'(out_pc), 64'(tgt));
  endtask

  // Scoreboard monitor: a handshake seen here completes at the next rising edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_entry: got pc %0h, expected no entry", out_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("stream_pc", 64'(out_pc), 64'(e.pc));
        check("stream_inst", 64'(out_inst), 64'(e.inst));
        check("stream_fault", 64'(out_fault), 64'(e.fault));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;
    for (int i = 0; i < 256; i++) dut.rom[i] = rom_word(i);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_out_pc", 64'(out_pc), 64'd0);
    check("rst_out_inst", 64'(out_inst), 64'd0);
    check("rst_out_fault", 64'(out_fault), 64'd0);
    check("rst_pc", 64'(pc), 64'd0);

    // Sequential fetch at full throughput
    out_ready = 1'b1;
    expect_seq(32'h0, 9);
    rst = 1'b0;
    @(posedge clk); #1;
    check("seq_valid_e1", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check("seq_valid_e2", 64'(out_valid), 64'd1);
    check("seq_pc_e2", 64'(pc), 64'h8);
    drain(cyc);
    out_ready = 1'b0;
    check("seq_throughput", 64'(cyc), 64'd9);

    // Backpressure
    do_redirect(32'h0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("bp_hold_valid", 64'(out_valid), 64'd1);
      check("bp_hold_pc", 64'(out_pc), 64'h0);
    end
    check("bp_fetch_pc", 64'(pc), 64'h8);
    expect_seq(32'h0, 3);
    out_ready = 1'b1;
    drain(cyc);
    out_ready = 1'b0;

    // Redirect while the queue holds 0x4 and 0x8
    do_redirect(32'h0, 1'b0);
    expect_seq(32'h0, 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    check("redir_head_before", 64'(out_pc), 64'h4);
    check("redir_pc_before", 64'(pc), 64'hC);
    do_redirect(32'h14, 1'b0);
    check("redir_inst", 64'(out_inst), 64'h112A002A);

    // Redirect on the same edge as a handshake with a full queue
    @(posedge clk); #1;
    expect_seq(32'h14, 1);
    do_redirect(32'h20, 1'b1);
    check("simul_inst", 64'(out_inst), 64'h34E700FF);
    check("simul_consumed_once", 64'(exp_q.size()), 64'd0);
    expect_seq(32'h20, 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("simul_target_next", 64'(exp_q.size()), 64'd0);

    // Misaligned fetch
    do_redirect(32'h402, 1'b0);
    check("mis_fault", 64'(out_fault), 64'd1);
    check("mis_inst", 64'(out_inst), 64'd0);
    exp_q.push_back('{pc: 32'h402, inst: 32'h0, fault: 1'b1});
    out_ready = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    check("mis_halt_valid", 64'(out_valid), 64'd0);
    check("mis_halt_pc", 64'(pc), 64'h406);
    out_ready = 1'b0;

    // Out-of-range fetch
    do_redirect(32'h400, 1'b0);
    check("oor_fault", 64'(out_fault), 64'd1);
    check("oor_inst", 64'(out_inst), 64'd0);
    exp_q.push_back('{pc: 32'h400, inst: 32'h0, fault: 1'b1});
    out_ready = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    check("oor_halt_valid", 64'(out_valid), 64'd0);
    check("oor_halt_pc", 64'(pc), 64'h404);
    out_ready = 1'b0;

    // Recovery, then asynchronous reset while streaming at pc 0x10
    do_redirect(32'h0, 1'b0);
    check("recover_fault", 64'(out_fault), 64'd0);
    check("recover_inst", 64'(out_inst), 64'h20100005);
    expect_seq(32'h0, 2);
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_reset_pc", 64'(pc), 64'h10);
    rst = 1'b1;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_out_pc", 64'(out_pc), 64'd0);
    check("async_rst_inst", 64'(out_inst), 64'd0);
    check("async_rst_pc", 64'(pc), 64'd0);
    #1;
    rst = 1'b0;
    check("async_rst_sb_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
    check("restart_valid_e1", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check("restart_valid_e2", 64'(out_valid), 64'd1);
    check("restart_out_pc", 64'(out_pc), 64'h0);
    expect_seq(32'h0, 3);
    drain(cyc);
    out_ready = 1'b0;
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
